// File: rtl/pic_pkg.sv
// Shared types, OCW2 command codes and priority-rank helper for the
// interrupt priority resolver.
package pic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_FROZEN  = 2'd2
    } pr_state_t;

    // OCW2 bits [7:5] (R, SL, EOI)
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_S_EOI        = 3'b011;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_ROT_S_EOI    = 3'b111;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;

    // Rank 0 is the level just above the current lowest-priority base.
    function automatic logic [2:0] rank(input logic [2:0] idx, input logic [2:0] base);
        return idx - base - 3'd1;
    endfunction

endpackage

// File: rtl/rotating_priority_encoder.sv
// Finds the set bit of an 8-bit vector with the lowest rank relative to base.
module rotating_priority_encoder (
    input  logic [7:0] vec,
    input  logic [2:0] base,
    output logic       valid,
    output logic [2:0] index
);

    logic [2:0] pos;

    // Scan from lowest priority to highest so the last hit is the winner.
    always_comb begin
        valid = 1'b0;
        index = 3'd0;
        pos   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            pos = base + 3'(k) + 3'd1;
            if (vec[pos]) begin
                valid = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/priority_resolver.sv
// Priority resolver ahead of the PIC control logic: masks requests, picks the
// winner under rotation, checks nesting against the ISR, handles the INTA
// freeze handshake and executes OCW2 EOI / priority commands.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no serviceable request
// ST_PENDING | INT_request raised, waiting for read_priority rise
// ST_FROZEN  | index latched, holding until freezing falls
module priority_resolver
    import pic_pkg::*;
#(
    parameter int NUM_IR = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IR-1:0] IRR,
    input  logic [NUM_IR-1:0] IMR,
    input  logic [NUM_IR-1:0] ISR,
    input  logic              ICW4_AEOI,
    input  logic [7:0]        OCW2,
    input  logic              OCW2_write,
    input  logic              read_priority,
    input  logic              freezing,
    output logic              INT_request,
    output logic              read_priority_ACK,
    output logic [2:0]        highest_index,
    output logic [NUM_IR-1:0] highest_onehot,
    output logic [NUM_IR-1:0] eoi_clear,
    output logic [2:0]        priority_base
);

    pr_state_t  state, state_nxt;
    logic [7:0] cand;
    logic       cand_valid, isr_valid;
    logic [2:0] best, isr_top;
    logic       req_ok;
    logic       rp_q1, rp_q2, fz_q;
    logic       rp_rise, fz_fall;
    logic       take_freeze, release_freeze;
    logic       rot_aeoi, rot_aeoi_nxt;
    logic [2:0] base_nxt;
    logic [7:0] eoi_nxt;
    logic [2:0] ocw2_lvl;
    logic       ocw2_unused;

    assign cand        = IRR & ~IMR;
    assign ocw2_lvl    = OCW2[2:0];
    assign ocw2_unused = ^OCW2[4:3];

    rotating_priority_encoder u_cand_enc (
        .vec   (cand),
        .base  (priority_base),
        .valid (cand_valid),
        .index (best)
    );

    rotating_priority_encoder u_isr_enc (
        .vec   (ISR),
        .base  (priority_base),
        .valid (isr_valid),
        .index (isr_top)
    );

    // Fully nested: a new request must outrank everything in service.
    assign req_ok = cand_valid &&
                    (!isr_valid || (rank(best, priority_base) < rank(isr_top, priority_base)));

    assign rp_rise = rp_q1 & ~rp_q2;
    assign fz_fall = fz_q & ~freezing;

    // Edge-detect registers for the INTA handshake levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp_q1 <= 1'b0;
            rp_q2 <= 1'b0;
            fz_q  <= 1'b0;
        end else begin
            rp_q1 <= read_priority;
            rp_q2 <= rp_q1;
            fz_q  <= freezing;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; the read_priority rise wins over a dropped request
    // so a vanished IRR still freezes as a spurious IR7.
    always_comb begin
        state_nxt      = state;
        take_freeze    = 1'b0;
        release_freeze = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_ok) state_nxt = ST_PENDING;
            end
            ST_PENDING: begin
                if (rp_rise) begin
                    state_nxt   = ST_FROZEN;
                    take_freeze = 1'b1;
                end else if (!req_ok) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FROZEN: begin
                if (fz_fall) begin
                    state_nxt      = ST_IDLE;
                    release_freeze = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // EOI pulses and rotation; OCW2 rotation overrides an AEOI rotation.
    always_comb begin
        eoi_nxt      = 8'd0;
        base_nxt     = priority_base;
        rot_aeoi_nxt = rot_aeoi;
        if (release_freeze && ICW4_AEOI) begin
            eoi_nxt = 8'd1 << highest_index;
            if (rot_aeoi) base_nxt = highest_index;
        end
        if (OCW2_write) begin
            case (OCW2[7:5])
                OCW2_NS_EOI: begin
                    if (isr_valid) eoi_nxt = eoi_nxt | (8'd1 << isr_top);
                end
                OCW2_S_EOI: begin
                    eoi_nxt = eoi_nxt | (8'd1 << ocw2_lvl);
                end
                OCW2_ROT_NS_EOI: begin
                    if (isr_valid) begin
                        eoi_nxt  = eoi_nxt | (8'd1 << isr_top);
                        base_nxt = isr_top;
                    end
                end
                OCW2_ROT_S_EOI: begin
                    eoi_nxt  = eoi_nxt | (8'd1 << ocw2_lvl);
                    base_nxt = ocw2_lvl;
                end
                OCW2_SET_PRIO:     base_nxt     = ocw2_lvl;
                OCW2_ROT_AEOI_SET: rot_aeoi_nxt = 1'b1;
                OCW2_ROT_AEOI_CLR: rot_aeoi_nxt = 1'b0;
                default: ;
            endcase
        end
    end

    // Registered outputs, latched index and rotation state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            INT_request       <= 1'b0;
            read_priority_ACK <= 1'b0;
            highest_index     <= 3'd0;
            highest_onehot    <= 8'd0;
            eoi_clear         <= 8'd0;
            priority_base     <= 3'd7;
            rot_aeoi          <= 1'b0;
        end else begin
            INT_request   <= (state_nxt == ST_PENDING);
            eoi_clear     <= eoi_nxt;
            priority_base <= base_nxt;
            rot_aeoi      <= rot_aeoi_nxt;
            if (take_freeze) begin
                highest_index     <= cand_valid ? best : 3'd7;
                highest_onehot    <= cand_valid ? (8'd1 << best) : 8'h80;
                read_priority_ACK <= ~read_priority_ACK;
            end else if (release_freeze) begin
                highest_onehot <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_priority_resolver.sv
// Directed bench for priority_resolver with hand-computed expectations.
module tb_priority_resolver;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] IRR, IMR, ISR;
    logic       ICW4_AEOI;
    logic [7:0] OCW2;
    logic       OCW2_write;
    logic       read_priority;
    logic       freezing;
    logic       INT_request;
    logic       read_priority_ACK;
    logic [2:0] highest_index;
    logic [7:0] highest_onehot;
    logic [7:0] eoi_clear;
    logic [2:0] priority_base;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    priority_resolver #(.NUM_IR(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .IRR               (IRR),
        .IMR               (IMR),
        .ISR               (ISR),
        .ICW4_AEOI         (ICW4_AEOI),
        .OCW2              (OCW2),
        .OCW2_write        (OCW2_write),
        .read_priority     (read_priority),
        .freezing          (freezing),
        .INT_request       (INT_request),
        .read_priority_ACK (read_priority_ACK),
        .highest_index     (highest_index),
        .highest_onehot    (highest_onehot),
        .eoi_clear         (eoi_clear),
        .priority_base     (priority_base)
    );

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ocw2_wr(input logic [7:0] w);
        OCW2       = w;
        OCW2_write = 1'b1;
        cyc(1);
        OCW2_write = 1'b0;
        OCW2       = 8'h00;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_int"},    {7'd0, INT_request}, 8'h00);
        check_eq({tag, "_ack"},    {7'd0, read_priority_ACK}, 8'h00);
        check_eq({tag, "_idx"},    {5'd0, highest_index}, 8'h00);
        check_eq({tag, "_onehot"}, highest_onehot, 8'h00);
        check_eq({tag, "_eoi"},    eoi_clear, 8'h00);
        check_eq({tag, "_base"},   {5'd0, priority_base}, 8'h07);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; IRR = 0; IMR = 0; ISR = 0; ICW4_AEOI = 0;
        OCW2 = 0; OCW2_write = 0; read_priority = 0; freezing = 0;
        cyc(2);
        check_reset_vals("reset");
        rst = 1'b0;
        cyc(1);

        // basic request and INTA handshake
        IRR = 8'h24;
        cyc(1);
        check_eq("t1_int_rise", {7'd0, INT_request}, 8'h01);
        read_priority = 1'b1; freezing = 1'b1;
        cyc(1);
        check_eq("t1_ack_wait", {7'd0, read_priority_ACK}, 8'h00);
        check_eq("t1_int_hold", {7'd0, INT_request}, 8'h01);
        cyc(1);
        check_eq("t1_ack",    {7'd0, read_priority_ACK}, 8'h01);
        check_eq("t1_int_fall", {7'd0, INT_request}, 8'h00);
        check_eq("t1_idx",    {5'd0, highest_index}, 8'h02);
        check_eq("t1_onehot", highest_onehot, 8'h04);

        // nesting: IR3 blocked by IR1 in service, IR0 preempts
        read_priority = 0; freezing = 0; IRR = 8'h08; ISR = 8'h02;
        cyc(1);
        check_eq("t2_onehot_clr", highest_onehot, 8'h00);
        check_eq("t2_no_req_a", {7'd0, INT_request}, 8'h00);
        cyc(1);
        check_eq("t2_no_req_b", {7'd0, INT_request}, 8'h00);
        IRR = 8'h09;
        cyc(1);
        check_eq("t2_req", {7'd0, INT_request}, 8'h01);
        read_priority = 1'b1; freezing = 1'b1;
        cyc(2);
        check_eq("t2_idx",    {5'd0, highest_index}, 8'h00);
        check_eq("t2_onehot", highest_onehot, 8'h01);
        check_eq("t2_ack",    {7'd0, read_priority_ACK}, 8'h00);

        // set priority L=4
        read_priority = 0; freezing = 0; IRR = 0; ISR = 0;
        cyc(1);
        ocw2_wr(8'hC4);
        check_eq("t3_base", {5'd0, priority_base}, 8'h04);
        check_eq("t3_eoi",  eoi_clear, 8'h00);
        IRR = 8'h21;
        cyc(1);
        check_eq("t3_req", {7'd0, INT_request}, 8'h01);
        read_priority = 1'b1; freezing = 1'b1;
        cyc(2);
        check_eq("t3_idx",    {5'd0, highest_index}, 8'h05);
        check_eq("t3_onehot", highest_onehot, 8'h20);

        // rotate on non-specific EOI
        read_priority = 0; freezing = 0; IRR = 0; ISR = 8'h0A;
        cyc(1);
        ocw2_wr(8'hA0);
        check_eq("t4_eoi",  eoi_clear, 8'h02);
        check_eq("t4_base", {5'd0, priority_base}, 8'h01);
        cyc(1);
        check_eq("t4_eoi_one_cycle", eoi_clear, 8'h00);

        // non-specific EOI with empty ISR, then specific EOI L=3
        ISR = 0;
        ocw2_wr(8'h20);
        check_eq("t4_ns_empty_eoi",  eoi_clear, 8'h00);
        check_eq("t4_ns_empty_base", {5'd0, priority_base}, 8'h01);
        ocw2_wr(8'h63);
        check_eq("t4_s_eoi",      eoi_clear, 8'h08);
        check_eq("t4_s_eoi_base", {5'd0, priority_base}, 8'h01);

        // masked request is ignored
        IRR = 8'h40; IMR = 8'h40;
        cyc(2);
        check_eq("t4_masked", {7'd0, INT_request}, 8'h00);

        // AEOI with rotation on IR6
        ICW4_AEOI = 1'b1;
        ocw2_wr(8'h80);
        IMR = 0;
        cyc(1);
        check_eq("t5_req", {7'd0, INT_request}, 8'h01);
        read_priority = 1'b1; freezing = 1'b1;
        cyc(2);
        check_eq("t5_idx", {5'd0, highest_index}, 8'h06);
        read_priority = 0; freezing = 0; IRR = 0;
        cyc(1);
        check_eq("t5_aeoi",   eoi_clear, 8'h40);
        check_eq("t5_base",   {5'd0, priority_base}, 8'h06);
        check_eq("t5_onehot", highest_onehot, 8'h00);
        cyc(1);
        check_eq("t5_aeoi_one_cycle", eoi_clear, 8'h00);

        // spurious IR7 when IRR vanishes before the rise is detected
        ICW4_AEOI = 1'b0;
        ocw2_wr(8'h00);
        IRR = 8'h01;
        cyc(1);
        check_eq("t6_req", {7'd0, INT_request}, 8'h01);
        read_priority = 1'b1; freezing = 1'b1;
        cyc(1);
        IRR = 0;
        check_eq("t6_ack_wait", {7'd0, read_priority_ACK}, 8'h00);
        cyc(1);
        check_eq("t6_idx",    {5'd0, highest_index}, 8'h07);
        check_eq("t6_onehot", highest_onehot, 8'h80);
        check_eq("t6_ack",    {7'd0, read_priority_ACK}, 8'h01);
        check_eq("t6_int",    {7'd0, INT_request}, 8'h00);

        // asynchronous reset while frozen
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("frozen_rst");
        cyc(1);
        rst = 1'b0; read_priority = 0; freezing = 0; IRR = 8'h01;
        cyc(1);
        check_eq("post_rst_req", {7'd0, INT_request}, 8'h01);
        check_eq("post_rst_ack", {7'd0, read_priority_ACK}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
